// File: rtl/prog_imem.sv
// rtl/prog_imem.sv - parametrised instruction memory with registered fetch port and streaming program load
//
// Fetch side: i_fetch_req/i_address are sampled while o_fetch_ready=1; one cycle later
// o_instr_valid pulses with o_instruction. Out-of-range addresses return 0 with o_addr_err.
// Load side: i_load_start enters LOAD; each i_load_valid beat writes i_load_data at the
// write pointer. The load ends on i_load_last or when the last word is written, then
// o_load_done pulses and o_load_count reports the words written.
// Ports: i_clk, i_reset (sync, active-high), i_fetch_req, i_address, o_fetch_ready,
// o_instruction, o_instr_valid, o_addr_err, i_load_start, i_load_valid, i_load_data,
// i_load_last, o_load_ready, o_load_done, o_load_count, o_parity_err.
// Optional macro IMEM_PARITY_EN: stores an even-parity bit per word and flags o_parity_err
// on fetch mismatch; when undefined o_parity_err is tied to 0.
module prog_imem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_address,
    output logic              o_fetch_ready,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_instr_valid,
    output logic              o_addr_err,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic              o_load_done,
    output logic [ADDR_W:0]   o_load_count,
    output logic              o_parity_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR_V = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W:0]   r_ptr;
    logic [DATA_W-1:0] r_instruction;
    logic              r_instr_valid;
    logic              r_addr_err;
    logic              r_load_done;
    logic [ADDR_W:0]   r_load_count;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_fetch;
    logic              w_write;
    logic              w_in_range;
    logic              w_load_end;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;

    assign w_fetch    = (r_state == RUN) && i_fetch_req;
    assign w_write    = (r_state == LOAD) && i_load_valid;
    // Zero-extend so DEPTH == 2**ADDR_W compares correctly.
    assign w_in_range = ({1'b0, i_address} < DEPTH_V);
    // Auto-stop on the final slot so the pointer never wraps.
    assign w_load_end = w_write && (i_load_last || (r_ptr == LAST_PTR_V));
    assign w_rd_idx   = i_address[IDX_W-1:0];
    assign w_wr_idx   = r_ptr[IDX_W-1:0];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; i_load_start is ignored while already loading.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (i_load_start) w_next_state = LOAD;
            LOAD:    if (w_load_end)   w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_fetch_ready = 1'b0;
        o_load_ready  = 1'b0;
        case (r_state)
            RUN:     o_fetch_ready = 1'b1;
            LOAD:    o_load_ready  = 1'b1;
            default: o_fetch_ready = 1'b1;
        endcase
    end

    // Storage array has no reset: program contents survive a control reset.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[w_wr_idx] <= i_load_data;
        end
    end

    // Fetch and load control datapath
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr         <= '0;
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_count  <= '0;
        end else begin
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
            r_load_done   <= 1'b0;
            if (w_fetch) begin
                r_instr_valid <= 1'b1;
                if (w_in_range) begin
                    r_instruction <= r_mem[w_rd_idx];
                end else begin
                    r_instruction <= '0;
                    r_addr_err    <= 1'b1;
                end
            end
            if ((r_state == RUN) && i_load_start) begin
                r_ptr <= '0;
            end
            if (w_write) begin
                r_ptr <= r_ptr + 1'b1;
                if (w_load_end) begin
                    r_load_done  <= 1'b1;
                    r_load_count <= r_ptr + 1'b1;
                end
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_par [0:DEPTH-1];
    logic r_parity_err;

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_par[w_wr_idx] <= ^i_load_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_fetch && w_in_range &&
                            ((^r_mem[w_rd_idx]) != r_par[w_rd_idx]);
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_instruction = r_instruction;
    assign o_instr_valid = r_instr_valid;
    assign o_addr_err    = r_addr_err;
    assign o_load_done   = r_load_done;
    assign o_load_count  = r_load_count;

endmodule

// File: tb/tb_prog_imem.sv
// tb/tb_prog_imem.sv - directed self-checking bench for prog_imem (DEPTH=16)
module tb_prog_imem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] address;
    logic              fetch_ready;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              addr_err;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              parity_err;

    int n_pass  = 0;
    int n_total = 0;

    prog_imem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_fetch_req   (fetch_req),
        .i_address     (address),
        .o_fetch_ready (fetch_ready),
        .o_instruction (instruction),
        .o_instr_valid (instr_valid),
        .o_addr_err    (addr_err),
        .i_load_start  (load_start),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .i_load_last   (load_last),
        .o_load_ready  (load_ready),
        .o_load_done   (load_done),
        .o_load_count  (load_count),
        .o_parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    logic [7:0] prog6 [0:5];
    logic [7:0] exp_w;

    initial begin
        prog6[0] = 8'h27; prog6[1] = 8'h61; prog6[2] = 8'h3C;
        prog6[3] = 8'hC1; prog6[4] = 8'h7B; prog6[5] = 8'h0F;

        reset = 1'b1; fetch_req = 1'b0; address = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset values
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_load_ready",  32'(load_ready),  32'd0);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr_err",    32'(addr_err),    32'd0);
        chk("rst_load_done",   32'(load_done),   32'd0);
        chk("rst_load_count",  32'(load_count),  32'd0);
        chk("rst_parity_err",  32'(parity_err),  32'd0);

        // Load six words terminated by load_last
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ld6_load_ready",  32'(load_ready),  32'd1);
        chk("ld6_fetch_ready", 32'(fetch_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1; load_data = prog6[i]; load_last = (i == 5);
            tick();
            if (i < 5) chk("ld6_done_early", 32'(load_done), 32'd0);
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("ld6_done",        32'(load_done),   32'd1);
        chk("ld6_count",       32'(load_count),  32'd6);
        chk("ld6_fetch_ready", 32'(fetch_ready), 32'd1);
        tick();
        chk("ld6_done_pulse",  32'(load_done),   32'd0);

        // Back-to-back fetch of 0..5
        for (int i = 0; i < 6; i++) begin
            fetch_req = 1'b1; address = 8'(i);
            tick();
            chk("f6_valid", 32'(instr_valid), 32'd1);
            chk("f6_instr", 32'(instruction), 32'(prog6[i]));
            chk("f6_err",   32'(addr_err),    32'd0);
        end
        fetch_req = 1'b0;
        tick();
        chk("idle_valid", 32'(instr_valid), 32'd0);
        chk("idle_hold",  32'(instruction), 32'h0F);

        // Out-of-range fetch
        fetch_req = 1'b1; address = 8'd20;
        tick();
        fetch_req = 1'b0;
        chk("oor_valid", 32'(instr_valid), 32'd1);
        chk("oor_err",   32'(addr_err),    32'd1);
        chk("oor_instr", 32'(instruction), 32'd0);
        chk("oor_par",   32'(parity_err),  32'd0);
        tick();
        chk("oor_err_pulse", 32'(addr_err), 32'd0);

        // Fill all 16 words without load_last: auto stop at full
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1; load_data = 8'hA0 + 8'(i); load_last = 1'b0;
            tick();
            if (i < 15) chk("full_done_early", 32'(load_done), 32'd0);
        end
        load_valid = 1'b0;
        chk("full_done",        32'(load_done),   32'd1);
        chk("full_count",       32'(load_count),  32'd16);
        chk("full_fetch_ready", 32'(fetch_ready), 32'd1);
        fetch_req = 1'b1; address = 8'd15;
        tick();
        chk("full_rd15", 32'(instruction), 32'hAF);
        address = 8'd0;
        tick();
        chk("full_rd0", 32'(instruction), 32'hA0);
        fetch_req = 1'b0;

        // Stalled load with fetch_req held high throughout
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        fetch_req = 1'b1; address = 8'd0;
        for (int c = 0; c < 10; c++) begin
            load_valid = ((c % 2) == 0);
            load_data  = 8'h50 + 8'((c / 2) * 3);
            load_last  = ((c % 2) == 0) && ((c / 2) == 4);
            tick();
            if (c < 9) chk("stall_no_valid", 32'(instr_valid), 32'd0);
            if (c == 8) begin
                chk("stall_done",  32'(load_done),  32'd1);
                chk("stall_count", 32'(load_count), 32'd5);
            end
            if (c == 9) begin
                chk("stall_rd0_valid", 32'(instr_valid), 32'd1);
                chk("stall_rd0",       32'(instruction), 32'h50);
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int i = 1; i < 5; i++) begin
            address = 8'(i);
            tick();
            exp_w = 8'h50 + 8'(i * 3);
            chk("stall_rd", 32'(instruction), 32'(exp_w));
        end
        fetch_req = 1'b0;
        // Slots past the short load keep the earlier full-load data
        fetch_req = 1'b1; address = 8'd5;
        tick();
        fetch_req = 1'b0;
        chk("stall_rd5_old", 32'(instruction), 32'hA5);

        // Reset after 3 of 10 load words
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 8'h11 * 8'(i + 1); load_last = 1'b0;
            tick();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("mid_load_ready",  32'(load_ready),  32'd0);
        chk("mid_count",       32'(load_count),  32'd0);
        chk("mid_done",        32'(load_done),   32'd0);
        tick();
        chk("mid_done_after",  32'(load_done),   32'd0);
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; address = 8'(i);
            tick();
            exp_w = (i < 3) ? 8'h11 * 8'(i + 1) : 8'h59;
            chk("mid_rd", 32'(instruction), 32'(exp_w));
        end
        fetch_req = 1'b0;

`ifdef IMEM_PARITY_EN
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'h27; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        fetch_req = 1'b1; address = 8'd0;
        tick();
        fetch_req = 1'b0;
        chk("par_clean", 32'(parity_err), 32'd0);
        dut.r_mem[0] = 8'h26;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("par_err",   32'(parity_err),  32'd1);
        chk("par_instr", 32'(instruction), 32'h26);
        chk("par_valid", 32'(instr_valid), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/prog_imem.md
Name: prog_imem

Overview:
- Parametrised, clocked instruction memory: next generation of the processor's fixed 8-bit instruction store.
- Adds a registered fetch port with a valid handshake.
- Adds a streaming program-load port, so software is written in at run time instead of hard-coded at reset.
- Sits between the fetch stage (PC → Address) and an external loader (UART/bootloader) that streams instruction words.

Parameters:
- DATA_W, 8: instruction word width in bits.
- ADDR_W, 8: address width in bits.
- DEPTH, 256: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- FetchReq  in  1  fetch request, sampled when FetchReady=1.
- Address  in  ADDR_W  fetch address.
- FetchReady  out  1  block accepts fetches.
- Instruction  out  DATA_W  fetched word.
- InstrValid  out  1  one-cycle pulse; Instruction is valid.
- AddrErr  out  1  one-cycle pulse with InstrValid when Address ≥ DEPTH.
- LoadStart  in  1  begin program load.
- LoadValid  in  1  LoadData valid.
- LoadData  in  DATA_W  word to write.
- LoadLast  in  1  marks final word of the load.
- LoadReady  out  1  block accepts load words.
- LoadDone  out  1  one-cycle pulse at end of load.
- LoadCount  out  ADDR_W+1  words written by the last completed load.
- ParityErr  out  1  see Optional Feature.

Behaviour:
- Clock and reset:
  - Single clock domain (Clock); Reset is synchronous and active-high.
  - Reset clears control state only. Memory contents are not cleared.
- Reset values:
  - state=RUN, FetchReady=1, LoadReady=0.
  - Instruction=0, InstrValid=0, AddrErr=0, LoadDone=0, LoadCount=0, ParityErr=0.
  - Internal write pointer = 0.
- States: RUN, LOAD.
  - FetchReady = (state==RUN).
  - LoadReady = (state==LOAD).
- Fetch (RUN):
  - FetchReq=1 in cycle N → cycle N+1: InstrValid=1, Instruction=mem[Address sampled at N]. Latency is 1 cycle.
  - Back-to-back requests are served every cycle.
  - Address ≥ DEPTH → Instruction=0 (NOP) and AddrErr=1, both with InstrValid.
  - No request → InstrValid=0; Instruction holds its last value.
- RUN → LOAD:
  - LoadStart=1 in RUN moves to LOAD next cycle and sets pointer=0.
  - A FetchReq in the same cycle is still served normally.
- LOAD:
  - FetchReq is ignored (FetchReady=0); InstrValid stays 0.
  - LoadValid=1 writes mem[ptr]=LoadData and increments ptr.
  - LOAD → RUN when the accepted word has LoadLast=1, or when ptr==DEPTH-1 is written (automatic stop at full; no wrap).
  - On exit, the next cycle has: LoadDone=1 for one cycle, LoadCount = total words written (1..DEPTH), FetchReady=1.
  - LoadStart asserted during LOAD is ignored.
  - LoadValid=0 cycles are stalls; ptr holds.
- Read/write ordering: a fetch of an address written earlier returns the new data. Reads and writes never occur in the same cycle, since the states are exclusive.
- Reset mid-load:
  - Returns to RUN with ptr=0 and LoadCount=0; no LoadDone pulse.
  - Words already written remain in memory.
- Widths: ptr and LoadCount are ADDR_W+1 bits so LoadCount can equal DEPTH=2**ADDR_W.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from LoadData at write time.
  - On fetch, parity is recomputed. ParityErr=1 with InstrValid on mismatch; Instruction is still returned unchanged.
  - Out-of-range fetches never flag ParityErr.
- Undefined: no parity storage; ParityErr is tied to 0.

Test Plan:
- Reset, then load 6 words 0x27,0x61,0x3C,0xC1,0x7B,0x0F with LoadLast on the 6th → LoadDone pulses once, LoadCount=6, then FetchReady=1.
- Fetch addresses 0..5 back-to-back → InstrValid high on 6 consecutive cycles, each 1 cycle after its request, Instruction=0x27,0x61,0x3C,0xC1,0x7B,0x0F.
- DEPTH=16, fetch Address=20 → InstrValid=1, AddrErr=1, Instruction=0x00. Load 16 words without LoadLast → auto stop, LoadCount=16.
- Load with LoadValid toggling every other cycle and FetchReq held high throughout → no InstrValid during LOAD, all words written correctly, LoadCount correct.
- Assert Reset after 3 of 10 load words → state RUN, LoadCount=0, no LoadDone. Fetch addresses 0..2 → return the newly loaded words.
- With IMEM_PARITY_EN, load 0x27, force-flip one stored data bit, fetch address 0 → ParityErr=1. Unforced fetch → ParityErr=0.
